// File: rtl/acc_integrate_dump_if.sv
// Sample/result bundle for acc_integrate_dump.
// master: the sample source plus the result consumer (drives ce, x, in_valid, clear).
// slave: the accumulator itself.
interface acc_integrate_dump_if #(
  parameter int IN_W   = 13,
  parameter int ACC_W  = 21,
  parameter int WINDOW = 8
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic                    ce;
  logic signed [IN_W-1:0]  x;
  logic                    in_valid;
  logic                    clear;
  logic signed [ACC_W-1:0] y;
  logic [CNT_W-1:0]        sample_cnt;
  logic signed [ACC_W-1:0] dump_data;
  logic                    dump_valid;
  logic                    dump_ovf;
  logic                    ovf;

  modport master (
    output ce, x, in_valid, clear,
    input  y, sample_cnt, dump_data, dump_valid, dump_ovf, ovf
  );

  modport slave (
    input  ce, x, in_valid, clear,
    output y, sample_cnt, dump_data, dump_valid, dump_ovf, ovf
  );
endinterface

// File: rtl/acc_integrate_dump.sv
// Signed integrate-and-dump accumulator.
// Sums sign-extended samples over WINDOW accepted samples, then publishes the
// window total with a one-cycle dump_valid pulse and restarts from zero.
// Build option: define ACC_SATURATE_EN to clamp the sum on overflow instead of
// wrapping. The port list is identical in both builds.
module acc_integrate_dump #(
  parameter int IN_W   = 13,
  parameter int ACC_W  = 21,
  parameter int WINDOW = 8
) (
  input logic                clk,
  input logic                rst,
  acc_integrate_dump_if.slave bus
);
  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // The sum is formed one bit wider than the accumulator; overflow means the
  // top two bits disagree, i.e. the value does not fit in ACC_W bits.
  function automatic logic add_ovf(input logic signed [ACC_W:0] s);
    add_ovf = s[ACC_W] ^ s[ACC_W-1];
  endfunction

  // Reduce the wide sum to ACC_W bits: clamp toward the overflow direction
  // in the saturating build, plain two's-complement wrap otherwise.
  function automatic logic signed [ACC_W-1:0] fix_result(input logic signed [ACC_W:0] s);
`ifdef ACC_SATURATE_EN
    if (add_ovf(s)) begin
      if (s[ACC_W]) begin
        fix_result = ACC_MIN;
      end else begin
        fix_result = ACC_MAX;
      end
    end else begin
      fix_result = s[ACC_W-1:0];
    end
`else
    fix_result = s[ACC_W-1:0];
`endif
  endfunction

  logic signed [ACC_W-1:0] y_r, y_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic signed [ACC_W-1:0] dump_data_r, dump_data_nxt_s;
  logic                    dump_valid_r, dump_valid_nxt_s;
  logic                    dump_ovf_r, dump_ovf_nxt_s;
  logic                    ovf_r, ovf_nxt_s;
  logic                    wflag_r, wflag_nxt_s;

  logic signed [ACC_W:0]   x_ext_s;
  logic signed [ACC_W:0]   sum_s;
  logic                    sum_ovf_s;
  logic signed [ACC_W-1:0] result_s;

  assign x_ext_s   = {{(ACC_W + 1 - IN_W){bus.x[IN_W-1]}}, bus.x};
  assign sum_s     = {y_r[ACC_W-1], y_r} + x_ext_s;
  assign sum_ovf_s = add_ovf(sum_s);
  assign result_s  = fix_result(sum_s);

  // Next-state: clear beats samples; the final sample of a window dumps and
  // restarts; dump_valid is a pulse that always falls unless re-fired.
  always_comb begin
    y_nxt_s          = y_r;
    cnt_nxt_s        = cnt_r;
    dump_data_nxt_s  = dump_data_r;
    dump_valid_nxt_s = 1'b0;
    dump_ovf_nxt_s   = dump_ovf_r;
    ovf_nxt_s        = ovf_r;
    wflag_nxt_s      = wflag_r;
    if (bus.ce) begin
      if (bus.clear) begin
        y_nxt_s     = '0;
        cnt_nxt_s   = '0;
        wflag_nxt_s = 1'b0;
        ovf_nxt_s   = 1'b0;
      end else if (bus.in_valid) begin
        ovf_nxt_s = ovf_r | sum_ovf_s;
        if (cnt_r == LAST_CNT) begin
          dump_data_nxt_s  = result_s;
          dump_valid_nxt_s = 1'b1;
          dump_ovf_nxt_s   = wflag_r | sum_ovf_s;
          y_nxt_s          = '0;
          cnt_nxt_s        = '0;
          wflag_nxt_s      = 1'b0;
        end else begin
          y_nxt_s     = result_s;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          wflag_nxt_s = wflag_r | sum_ovf_s;
        end
      end else begin
        // No qualified sample: hold everything (dump_valid already dropped).
        y_nxt_s = y_r;
      end
    end else begin
      // Clock enable low freezes the window; only the dump pulse falls.
      y_nxt_s = y_r;
    end
  end

  // State registers with synchronous reset that overrides ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r          <= '0;
      cnt_r        <= '0;
      dump_data_r  <= '0;
      dump_valid_r <= 1'b0;
      dump_ovf_r   <= 1'b0;
      ovf_r        <= 1'b0;
      wflag_r      <= 1'b0;
    end else begin
      y_r          <= y_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dump_data_r  <= dump_data_nxt_s;
      dump_valid_r <= dump_valid_nxt_s;
      dump_ovf_r   <= dump_ovf_nxt_s;
      ovf_r        <= ovf_nxt_s;
      wflag_r      <= wflag_nxt_s;
    end
  end

  assign bus.y          = y_r;
  assign bus.sample_cnt = cnt_r;
  assign bus.dump_data  = dump_data_r;
  assign bus.dump_valid = dump_valid_r;
  assign bus.dump_ovf   = dump_ovf_r;
  assign bus.ovf        = ovf_r;
endmodule
